// File: rtl/lib_voq_requester.sv
// lib_voq_requester
// -----------------
// Requester-side front end of one switch input for the NxM separable
// allocators. Incoming flits are sorted into M virtual output queues (one
// circular FIFO per destination). The block presents one M-bit request row
// to the allocator, takes back this input's grant row, and sends the granted
// head flit towards the crossbar one cycle later.
//
// Ports
//   clk        clock
//   reset_n    synchronous active-low reset; flushes every VOQ
//   i_data     flit to enqueue
//   i_dest     destination output of i_data (selects the VOQ)
//   i_valid    enqueue request
//   o_ready    the VOQ selected by i_dest has room (combinational on i_dest)
//   o_request  request row, bit k set while VOQ k is non-empty
//   i_grant    grant row returned by the allocator for this input
//   o_data     dequeued flit (holds its value between dequeues)
//   o_dest     VOQ index of the dequeued flit
//   o_valid    one-cycle pulse per dequeue
//   o_error    sticky flag for malformed grants (multi-hot or unrequested)

module lib_voq_requester #(
  parameter int M     = 4,
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     i_data,
  input  logic [$clog2(M)-1:0] i_dest,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [0:M-1]         o_request,
  input  logic [0:M-1]         i_grant,
  output logic [WIDTH-1:0]     o_data,
  output logic [$clog2(M)-1:0] o_dest,
  output logic                 o_valid,
  output logic                 o_error
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(M);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // VOQ storage and bookkeeping
  logic [WIDTH-1:0] mem_q    [M][DEPTH];
  logic [WIDTH-1:0] mem_d    [M][DEPTH];
  logic [PW-1:0]    wr_ptr_q [M];
  logic [PW-1:0]    wr_ptr_d [M];
  logic [PW-1:0]    rd_ptr_q [M];
  logic [PW-1:0]    rd_ptr_d [M];
  logic [CW-1:0]    count_q  [M];
  logic [CW-1:0]    count_d  [M];

  // Registered dequeue side
  logic [WIDTH-1:0] o_data_q,  o_data_d;
  logic [DW-1:0]    o_dest_q,  o_dest_d;
  logic             o_valid_q, o_valid_d;
  logic             o_error_q, o_error_d;

  // Per-cycle decisions
  logic             dest_in_range;
  logic             enq_fire;
  logic [0:M-1]     legal_grant;
  logic             deq_fire;
  logic [DW-1:0]    deq_idx;
  logic             grant_multi;
  logic             grant_stray;

  // Request row comes only from registered counts, so there is no
  // combinational path from i_valid or i_grant to o_request.
  always_comb begin
    o_request = '0;
    for (int k = 0; k < M; k++) begin
      o_request[k] = (count_q[k] != '0);
    end
  end

  // Enqueue side. The range guard only matters when M is not a power of 2.
  // A simultaneous dequeue from a full VOQ does not open it up this cycle.
  always_comb begin
    dest_in_range = (32'(i_dest) < M);
    o_ready       = dest_in_range && (count_q[i_dest] != FULL_COUNT);
    enq_fire      = i_valid && o_ready;
  end

  // Grant decode. Only grant bits backed by a request are honoured; the
  // lowest such index wins if the allocator sent more than one bit.
  always_comb begin
    legal_grant = i_grant & o_request;
    deq_fire    = 1'b0;
    deq_idx     = '0;
    for (int k = M - 1; k >= 0; k--) begin
      if (legal_grant[k]) begin
        deq_fire = 1'b1;
        deq_idx  = DW'(k);
      end
    end
    grant_multi = ($countones(i_grant) > 1);
    grant_stray = |(i_grant & ~o_request);
  end

  // Next-state for the VOQs. The head is read from the pre-edge read
  // pointer, so an enqueue and dequeue on the same non-empty VOQ never
  // touch the same slot. Pointers wrap naturally since DEPTH is 2**PW.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (enq_fire) begin
      mem_d[i_dest][wr_ptr_q[i_dest]] = i_data;
      wr_ptr_d[i_dest] = wr_ptr_q[i_dest] + PW'(1);
    end

    if (deq_fire) begin
      rd_ptr_d[deq_idx] = rd_ptr_q[deq_idx] + PW'(1);
    end

    for (int k = 0; k < M; k++) begin
      count_d[k] = count_q[k]
                 + CW'(enq_fire && (32'(i_dest) == k))
                 - CW'(deq_fire && (32'(deq_idx) == k));
    end
  end

  // Next-state for the output registers. o_data/o_dest hold between
  // dequeues; o_error only ever accumulates.
  always_comb begin
    o_data_d  = o_data_q;
    o_dest_d  = o_dest_q;
    o_valid_d = deq_fire;
    o_error_d = o_error_q | grant_multi | grant_stray;
    if (deq_fire) begin
      o_data_d = mem_q[deq_idx][rd_ptr_q[deq_idx]];
      o_dest_d = deq_idx;
    end
  end

  // Control state with synchronous reset; reset wins over any grant so no
  // dequeue is reported for the reset cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < M; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        count_q[k]  <= '0;
      end
      o_data_q  <= '0;
      o_dest_q  <= '0;
      o_valid_q <= 1'b0;
      o_error_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      o_data_q  <= o_data_d;
      o_dest_q  <= o_dest_d;
      o_valid_q <= o_valid_d;
      o_error_q <= o_error_d;
    end
  end

  // Flit storage needs no reset: stale slots are unreachable once the
  // pointers and counts are cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign o_data  = o_data_q;
  assign o_dest  = o_dest_q;
  assign o_valid = o_valid_q;
  assign o_error = o_error_q;

endmodule

// File: doc/lib_voq_requester.md
Name: lib_voq_requester

Overview:
- Per-input virtual output queue (VOQ) front end for the NxM separable allocators.
- Buffers incoming flits into M per-destination circular FIFOs and drives one M-bit request row into the allocator.
- Consumes that input's returned grant row and dequeues the granted flit towards the crossbar.
- Instantiated N times, one per switch input; it is the requester end of the allocator request/grant interface.

Parameters:
M, 4, number of resources (outputs), and therefore the number of VOQs
DEPTH, 4, entries per VOQ; must be a power of 2 and at least 2
WIDTH, 8, flit data width in bits

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
i_data  input  WIDTH  flit to enqueue
i_dest  input  $clog2(M)  destination output, selects the VOQ
i_valid  input  1  enqueue request
o_ready  output  1  enqueue accepted this cycle when high together with i_valid
o_request  output  [0:M-1]  request row to allocator; bit k means VOQ k is non-empty
i_grant  input  [0:M-1]  this input's grant row from the allocator
o_data  output  WIDTH  dequeued flit
o_dest  output  $clog2(M)  index of the granted VOQ
o_valid  output  1  o_data/o_dest valid; single-cycle pulse per dequeue
o_error  output  1  sticky protocol-violation flag

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: all VOQ read/write pointers and counts = 0; o_request = 0; o_valid = 0; o_data = 0; o_dest = 0; o_error = 0.
- Reset mid-operation flushes all queued flits; no dequeue occurs in the reset cycle.
- VOQ storage: each VOQ is a DEPTH-entry circular buffer with a $clog2(DEPTH)-bit rd/wr pointer and a $clog2(DEPTH)+1-bit count. Pointers wrap modulo DEPTH.
- Enqueue: o_ready = (count[i_dest] != DEPTH), combinational on i_dest. It does not depend on i_valid or i_grant.
  - A flit is written when i_valid & o_ready; wr pointer and count update at the clock edge.
  - No bypass: a dequeue from a full VOQ in the same cycle does not make o_ready high.
- Request: o_request[k] = (count[k] != 0), derived from registered state only, never from i_valid.
  - Flit enqueued at edge t → request visible in cycle t+1.
  - No combinational path from i_grant to o_request.
- Grant handling:
  - Valid grant: exactly one bit k set AND o_request[k] = 1.
    - Head of VOQ k is registered into o_data, and k into o_dest; o_valid = 1 in the next cycle.
    - rd pointer and count of VOQ k update at the same edge.
    - o_request[k] drops next cycle if that was the last entry.
  - Multi-hot grant: the lowest-index bit that also has its request bit set is honoured; o_error sets.
  - Grant bit on a non-requesting VOQ: that bit is ignored; o_error sets.
  - All-zero grant: no dequeue; o_valid = 0 next cycle; o_data holds its last value.
- Simultaneous enqueue and dequeue on the same VOQ: both occur. Count is unchanged when neither the full nor the empty boundary blocks the operation.
- Simultaneous enqueue to an empty VOQ and a grant for it: the grant is illegal (request was 0), so it is ignored and o_error sets.
- Latency: enqueue to request = 1 cycle; grant to o_valid = 1 cycle. Back-to-back grants to the same VOQ give one flit per cycle in FIFO order.
- o_error: sticky until reset.

Test Plan:
1. Reset, then idle → o_request = 0000, o_ready = 1, o_valid = 0, o_error = 0.
2. Enqueue 0xA1 (dest 2) at cycle 1; grant 0010 at cycle 3 → o_request = 0010 from cycle 2; o_valid = 1, o_data = 0xA1, o_dest = 2 in cycle 4; o_request = 0000 in cycle 4.
3. Enqueue 0x01..0x04 to dest 1 → o_ready low with i_dest = 1, still high with i_dest = 0. Enqueue a 5th flit while granting 0100 → 5th flit rejected, 0x01 dequeued. Then enqueue 0x05, and dequeue 0x02..0x05 in order, exercising pointer wrap.
4. VOQ 3 holds 2 flits; enqueue to dest 3 and grant 0001 on the same cycle → count stays 2, dequeued flit is the oldest.
5. VOQs 0 and 3 non-empty; apply grant 1001 → VOQ 0 dequeued, o_error = 1 and remains 1. Apply grant 0100 with VOQ 1 empty → no dequeue, o_valid = 0.
6. Three VOQs loaded; assert reset_n = 0 for one cycle during a grant → no o_valid; all counts, o_request and o_error return to 0 on the next cycle.
